// File: rtl/jk_pkg.sv
// Shared encodings for the JK register bank: mode select and per-cell JK actions.
package jk_pkg;

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // {J,K} pair as seen by a single JK cell
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_act_e;

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flip-flop with asynchronous active-high clear.
module jk_cell
  import jk_pkg::*;
(
  input  logic CK,
  input  logic CLR,
  input  logic J,
  input  logic K,
  output logic Q
);

  logic q_d;
  logic q_q;

  // Decode the JK pair into the next cell value
  always_comb begin
    q_d = q_q;
    case (jk_act_e'({J, K}))
      JK_HOLD:   q_d = q_q;
      JK_RESET:  q_d = 1'b0;
      JK_SET:    q_d = 1'b1;
      JK_TOGGLE: q_d = ~q_q;
      default:   q_d = q_q;
    endcase
  end

  // Cell state register, cleared asynchronously
  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: rtl/jk_counter_bank.sv
// WIDTH-bit bank of JK cells acting as JK register, modulo up/down counter
// or parallel-load register, with a registered terminal-count pulse on wrap.
module jk_counter_bank
  import jk_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int MODULUS    = 16,
  parameter int PRESET_VAL = 0
) (
  input  logic             CK,
  input  logic             CLR,
  input  logic             PR,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             TC
);

  // Top count value as a WIDTH-bit constant; MODULUS=2^WIDTH yields all ones
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MODULUS - 1);
  // One extra bit so the out-of-range test is never true when MODULUS=2^WIDTH
  localparam logic [WIDTH:0]   MOD_V    = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] PRESET_V = WIDTH'(PRESET_VAL);

  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] j_v;
  logic [WIDTH-1:0] k_v;
  logic [WIDTH-1:0] cnt_nxt;
  logic             wrap;
  logic             tc_d;
  logic             tc_q;

  // Mode decode: every operation is expressed as a J/K vector for the cells
  always_comb begin
    j_v     = '0;
    k_v     = '0;
    cnt_nxt = q_w;
    wrap    = 1'b0;
    tc_d    = 1'b0;
    if (PR) begin
      j_v = PRESET_V;
      k_v = ~PRESET_V;
    end else if (EN) begin
      case (mode_e'(MODE))
        MODE_JK: begin
          j_v = J;
          k_v = K;
        end
        MODE_UP: begin
          if (q_w >= MAX_V) begin
            cnt_nxt = '0;
            wrap    = 1'b1;
          end else begin
            cnt_nxt = q_w + 1'b1;
          end
          j_v  = cnt_nxt ^ q_w;
          k_v  = cnt_nxt ^ q_w;
          tc_d = wrap;
        end
        MODE_DOWN: begin
          if (q_w == '0) begin
            cnt_nxt = MAX_V;
            wrap    = 1'b1;
          end else if ({1'b0, q_w} >= MOD_V) begin
            // Out-of-range values re-enter at the top without signalling a wrap
            cnt_nxt = MAX_V;
          end else begin
            cnt_nxt = q_w - 1'b1;
          end
          j_v  = cnt_nxt ^ q_w;
          k_v  = cnt_nxt ^ q_w;
          tc_d = wrap;
        end
        MODE_LOAD: begin
          j_v = D;
          k_v = ~D;
        end
        default: begin
          j_v = '0;
          k_v = '0;
        end
      endcase
    end
  end

  // The state bits themselves: one JK cell per bit
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .CK  (CK),
      .CLR (CLR),
      .J   (j_v[i]),
      .K   (k_v[i]),
      .Q   (q_w[i])
    );
  end

  // Terminal-count pulse register, high for the cycle after a wrap edge
  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) tc_q <= 1'b0;
    else     tc_q <= tc_d;
  end

  assign Q  = q_w;
  assign QN = ~q_w;
  assign TC = tc_q;

endmodule

// File: tb/tb_jk_counter_bank.sv
// Bench for jk_counter_bank (WIDTH=4, MODULUS=10, PRESET_VAL=5):
// directed reset/clear sequences, a vector table, and randomized cycles
// checked against a behavioural model.
module tb_jk_counter_bank;

  localparam int W  = 4;
  localparam int M  = 10;
  localparam int PV = 5;

  logic         CK = 1'b0;
  logic         CLR, PR, EN;
  logic [1:0]   MODE;
  logic [W-1:0] J, K, D, Q, QN;
  logic         TC;

  int total = 0;
  int bad   = 0;

  jk_counter_bank #(.WIDTH(W), .MODULUS(M), .PRESET_VAL(PV)) dut (
    .CK(CK), .CLR(CLR), .PR(PR), .EN(EN), .MODE(MODE),
    .J(J), .K(K), .D(D), .Q(Q), .QN(QN), .TC(TC)
  );

  always #5 CK = ~CK;

  typedef struct {
    logic         pr;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] d;
    logic [W-1:0] eq;
    logic         etc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int eq, input int etc);
    chk({nm, ".Q"},  32'(Q),  32'(eq));
    chk({nm, ".QN"}, 32'(QN), 32'((~eq) & 15));
    chk({nm, ".TC"}, 32'(TC), 32'(etc));
  endtask

  function automatic void add(input logic pr, input logic en, input logic [1:0] mode,
                              input logic [W-1:0] j, input logic [W-1:0] k,
                              input logic [W-1:0] d, input logic [W-1:0] eq,
                              input logic etc);
    vec_t v;
    v.pr = pr; v.en = en; v.mode = mode; v.j = j; v.k = k; v.d = d;
    v.eq = eq; v.etc = etc;
    tbl.push_back(v);
  endfunction

  // Apply controls just after an edge, then sample 1 time unit after the next edge
  task automatic drive(input logic pr, input logic en, input logic [1:0] mode,
                       input logic [W-1:0] j, input logic [W-1:0] k, input logic [W-1:0] d);
    PR = pr; EN = en; MODE = mode; J = j; K = k; D = d;
    @(posedge CK);
    #1;
  endtask

  // Behavioural model: plain integer arithmetic straight from the mode rules
  function automatic void model(inout int q, output int tc, input int pr, input int en,
                                input int mode, input int j, input int k, input int d);
    tc = 0;
    if (pr != 0) q = PV;
    else if (en == 0) q = q;
    else if (mode == 0) begin
      int r = 0;
      for (int b = 0; b < W; b++) begin
        int qb = (q >> b) & 1;
        int jb = (j >> b) & 1;
        int kb = (k >> b) & 1;
        int nb;
        if (jb == 1 && kb == 1)      nb = 1 - qb;
        else if (jb == 1)            nb = 1;
        else if (kb == 1)            nb = 0;
        else                         nb = qb;
        r += nb << b;
      end
      q = r;
    end else if (mode == 1) begin
      if (q >= M - 1) begin q = 0; tc = 1; end
      else q = q + 1;
    end else if (mode == 2) begin
      if (q == 0) begin q = M - 1; tc = 1; end
      else if (q >= M) q = M - 1;
      else q = q - 1;
    end else q = d;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mq, mtc;
    CLR = 1'b1; PR = 0; EN = 0; MODE = 2'b00; J = 0; K = 0; D = 0;

    // Reset state and clear held across an edge
    #12;
    chk_all("reset", 0, 0);
    @(posedge CK); #1;
    CLR = 1'b0;

    // Async clear mid-cycle from Q=7
    drive(0, 1, 2'b11, 0, 0, 4'd7);
    chk_all("load7", 7, 0);
    #3;
    CLR = 1'b1;
    #1;
    chk_all("async_clr", 0, 0);
    @(posedge CK); #1;
    chk_all("clr_hold1", 0, 0);
    @(posedge CK); #1;
    chk_all("clr_hold2", 0, 0);
    CLR = 1'b0;

    // Vector table
    add(0, 1, 2'b11, 0, 0, 4'd5, 4'd5, 0);
    add(0, 1, 2'b00, 4'b1010, 4'b0000, 0, 4'b1111, 0);
    add(0, 1, 2'b00, 4'b1111, 4'b1111, 0, 4'b0000, 0);
    add(0, 1, 2'b00, 4'b0000, 4'b0001, 0, 4'b0000, 0);
    for (int i = 1; i <= 9; i++) add(0, 1, 2'b01, 0, 0, 0, 4'(i), 0);
    add(0, 1, 2'b01, 0, 0, 0, 4'd0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 2'b01, 0, 0, 0, 4'd0, 0);
    add(0, 1, 2'b11, 0, 0, 4'd1, 4'd1, 0);
    add(0, 1, 2'b10, 0, 0, 0, 4'd0, 0);
    add(0, 1, 2'b10, 0, 0, 0, 4'd9, 1);
    add(0, 1, 2'b10, 0, 0, 0, 4'd8, 0);
    add(0, 1, 2'b11, 0, 0, 4'd13, 4'd13, 0);
    add(0, 1, 2'b10, 0, 0, 0, 4'd9, 0);
    add(0, 1, 2'b11, 0, 0, 4'd13, 4'd13, 0);
    add(0, 1, 2'b01, 0, 0, 0, 4'd0, 1);
    add(1, 1, 2'b11, 0, 0, 4'd3, 4'd5, 0);
    add(0, 1, 2'b01, 0, 0, 0, 4'd6, 0);
    add(1, 0, 2'b01, 0, 0, 0, 4'd5, 0);
    add(0, 1, 2'b00, 4'b1000, 4'b0100, 0, 4'd9, 0);
    add(0, 1, 2'b01, 0, 0, 0, 4'd0, 1);
    add(0, 1, 2'b01, 0, 0, 0, 4'd1, 0);
    add(1, 1, 2'b10, 0, 0, 0, 4'd5, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].pr, tbl[i].en, tbl[i].mode, tbl[i].j, tbl[i].k, tbl[i].d);
      chk_all($sformatf("vec%0d", i), int'(tbl[i].eq), int'(tbl[i].etc));
    end

    // Modulus-2 style back-to-back wraps are covered by random; here CLR beats PR
    PR = 1'b1; MODE = 2'b01; EN = 1'b1;
    CLR = 1'b1;
    #1;
    chk_all("clr_pr_async", 0, 0);
    @(posedge CK); #1;
    chk_all("clr_pr_edge", 0, 0);
    CLR = 1'b0; PR = 1'b0;
    drive(0, 1, 2'b01, 0, 0, 0);
    chk_all("post_clr_up", 1, 0);

    // Randomized cycles against the model
    mq = 1; mtc = 0;
    for (int n = 0; n < 400; n++) begin
      logic          rpr, ren;
      logic [1:0]    rmode;
      logic [W-1:0]  rj, rk, rd;
      rpr   = ($urandom_range(0, 15) == 0);
      ren   = ($urandom_range(0, 7) != 0);
      rmode = 2'($urandom_range(0, 3));
      rj    = 4'($urandom);
      rk    = 4'($urandom);
      rd    = 4'($urandom);
      model(mq, mtc, int'(rpr), int'(ren), int'(rmode), int'(rj), int'(rk), int'(rd));
      drive(rpr, ren, rmode, rj, rk, rd);
      chk_all($sformatf("rnd%0d", n), mq, mtc);
      if ($urandom_range(0, 39) == 0) begin
        #2;
        CLR = 1'b1;
        #1;
        chk_all($sformatf("rnd_clr%0d", n), 0, 0);
        CLR = 1'b0;
        mq = 0; mtc = 0;
        @(posedge CK); #1;
        CLR = 1'b0;
        // Edge passed while CLR was low with the previous controls applied
        model(mq, mtc, int'(rpr), int'(ren), int'(rmode), int'(rj), int'(rk), int'(rd));
        chk_all($sformatf("rnd_after_clr%0d", n), mq, mtc);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
